snn_spike_scheduler: RTL and testbench
======================================

// Module: snn_spike_scheduler
// PURPOSE
// - Timestep controller for the SNN core: edge-detects N_IN spike inputs, arbitrates them round-robin
//   onto one shared synaptic-update port, then issues one membrane leak per timestep.
// - Sits between spike sources and the neuron datapath inside snn_fpga_top.
// - Emits a one-cycle tick at every timestep boundary.
// PARAMETERS
// - N_IN            4   number of spike input channels
// - TIMESTEP_CYCLES 16  RUN-phase length in clk cycles per timestep (>=2)
// - IDX_W           $clog2(N_IN)  width of upd_idx (derived, not overridden)
// PORTS
// - clk         in   1      system clock, all logic rising-edge
// - rst         in   1      asynchronous, active-low reset (0 = reset)
// - enable      in   1      1 = run timesteps; 0 = stop at next timestep boundary
// - spike_in    in   N_IN   level spike inputs; each rising edge = one spike
// - upd_valid   out  1      synaptic update request to datapath
// - upd_idx     out  IDX_W  input channel being applied
// - upd_ready   in   1      datapath accepts update (handshake = valid & ready)
// - leak_valid  out  1      leak request to datapath
// - leak_ready  in   1      datapath accepts leak
// - tick        out  1      one-cycle pulse, timestep complete
// - step_count  out  16     completed timesteps, wraps 0xFFFF->0
// - drop_flags  out  N_IN   sticky: spike lost on channel i
// - busy        out  1      state != IDLE
// BEHAVIOUR
// - Reset (rst=0, async): state=IDLE; all outputs 0; pend, next_pend, edge regs, rr pointer, timer cleared.
// - Edge detect: spk[i] = spike_in[i] & ~spike_q[i]. Spike detected 1 cycle after the input rises.
// - FSM: IDLE -> RUN when enable=1 (timer loaded TIMESTEP_CYCLES-1).
//   - RUN: spk sets pend; timer decrements; at timer==0 -> DRAIN.
//   - DRAIN: issue remaining pend; when pend==0 and no handshake pending -> LEAK.
//   - LEAK: leak_valid=1 until leak_ready -> TICK.
//   - TICK: tick=1 one cycle; step_count+1; pend <= next_pend; next_pend cleared.
//     Exits to RUN if enable=1, else IDLE.
// - In DRAIN/LEAK/TICK, spk sets next_pend (counts toward the following timestep), never pend.
// - In IDLE, spikes are ignored. spike_q still tracks the inputs, so a held input does not spike on entry.
// - Arbitration (RUN and DRAIN): when upd_valid=0 and pend!=0, grant the first set bit of pend
//   searching from rr_ptr+1 upward, with wrap.
//   - upd_valid/upd_idx are registered and held stable until upd_ready.
//   - On handshake: clear pend[idx]; rr_ptr <= idx; upd_valid drops for >=1 cycle.
//   - Maximum throughput is therefore one update per 2 cycles.
// - Drops: a spk on channel i while the target bit is already set, and not cleared that cycle, sets drop_flags[i].
//   - drop_flags are cleared only by reset.
//   - A spk in the same cycle as channel i's handshake re-sets pend[i] and is not a drop.
// - enable=0 mid-timestep: the current timestep completes (DRAIN, LEAK, TICK), then IDLE.
//   next_pend moves into pend at TICK and is held for the next run.
// - Simultaneous spikes on all channels: all latched the same cycle, served in rr order.
// - leak_valid and upd_valid are never both 1.
// STRUCTURE
// - snn_pkg: sched_state_t enum {IDLE,RUN,DRAIN,LEAK,TICK}; STEP_W=16 localparam.
// - Sub-module snn_rr_arbiter #(N): inputs req[N], ptr; outputs gnt_idx, gnt_any.
//   Combinational one-hot rotate/priority logic.
// - Top: edge detect, pend/next_pend, FSM, timer, handshake registers.
// TESTING
// - Reset/idle: rst=0 while spike_in toggles -> all outputs 0.
//   Release with enable=0 -> busy=0 and no upd_valid.
// - Single spike: enable=1, ch2 rises at cycle 3 of RUN, upd_ready=1 -> one handshake with upd_idx=2.
//   Then one leak, tick after 16 RUN cycles plus drain, step_count=1.
// - Round-robin: all 4 channels rise together, rr_ptr=0 -> grant order 1,2,3,0.
//   upd_ready=0 for 5 cycles holds idx=1 stable.
// - Drop: ch0 rises twice while pend[0]=1 and upd_ready=0 -> drop_flags=4'b0001.
//   Only one update for ch0.
// - Boundary: spike on ch3 during DRAIN -> not served this step.
//   Served as the first update after the next tick.
// - Stop and reset: enable=0 mid-RUN -> the step completes, tick, then IDLE.
//   rst=0 during LEAK -> leak_valid drops immediately and step_count=0.

Source files
------------

// File: rtl/snn_spike_scheduler_pkg.sv
// -----------------------------------------------------------------------------
// snn_spike_scheduler_pkg
// Shared types and constants for the SNN timestep scheduler.
//   sched_state_t : scheduler FSM states
//   STEP_W        : width of the completed-timestep counter
//   rr_wrap()     : modular channel index used by the round-robin search
// -----------------------------------------------------------------------------
package snn_spike_scheduler_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        RUN   = 3'd1,
        DRAIN = 3'd2,
        LEAK  = 3'd3,
        TICK  = 3'd4
    } sched_state_t;

    localparam int STEP_W = 16;

    // Channel that sits 'off' positions after 'base' on a ring of 'n' channels.
    function automatic int rr_wrap(input int base, input int off, input int n);
        return (base + off) % n;
    endfunction

endpackage

// File: rtl/snn_spike_scheduler_if.sv
// -----------------------------------------------------------------------------
// snn_spike_scheduler_if
// Handshake bundle between the spike scheduler and the neuron datapath.
//   upd_valid/upd_idx/upd_ready : synaptic update request, one channel at a time
//   leak_valid/leak_ready       : once-per-timestep membrane leak request
// Modports: master = scheduler side, slave = datapath side.
// -----------------------------------------------------------------------------
interface snn_spike_scheduler_if #(
    parameter int IDX_W = 2
);
    logic             upd_valid;
    logic [IDX_W-1:0] upd_idx;
    logic             upd_ready;
    logic             leak_valid;
    logic             leak_ready;

    modport master (
        output upd_valid,
        output upd_idx,
        output leak_valid,
        input  upd_ready,
        input  leak_ready
    );

    modport slave (
        input  upd_valid,
        input  upd_idx,
        input  leak_valid,
        output upd_ready,
        output leak_ready
    );
endinterface

// File: rtl/snn_spike_scheduler_rr_arbiter.sv
// -----------------------------------------------------------------------------
// snn_spike_scheduler_rr_arbiter
// Combinational round-robin picker: returns the first set request bit found
// searching from ptr+1 upward, wrapping around.
//   req     in  N      pending request per channel
//   ptr     in  IW     last channel served
//   gnt_idx out IW     chosen channel (0 when nothing requested)
//   gnt_any out 1      at least one request is pending
// -----------------------------------------------------------------------------
module snn_spike_scheduler_rr_arbiter
    import snn_spike_scheduler_pkg::*;
#(
    parameter int N  = 4,
    parameter int IW = $clog2(N)
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    output logic [IW-1:0] gnt_idx,
    output logic          gnt_any
);

    // Priority search: scan from the farthest offset down so the nearest
    // requester after ptr is the one left standing.
    always_comb begin
        int idx_v;
        idx_v   = 0;
        gnt_idx = '0;
        gnt_any = 1'b0;
        for (int k = N; k >= 1; k--) begin
            idx_v = rr_wrap(int'(ptr), k, N);
            if (req[IW'(idx_v)]) begin
                gnt_idx = IW'(idx_v);
                gnt_any = 1'b1;
            end else begin
                gnt_idx = gnt_idx;
            end
        end
    end

endmodule

// File: rtl/snn_spike_scheduler.sv
// -----------------------------------------------------------------------------
// snn_spike_scheduler
// Timestep controller for the SNN core. Edge-detects spike inputs, serves
// them round-robin over one synaptic-update port, issues one leak per
// timestep and pulses tick at every timestep boundary.
//   clk, rst (async, active-low)
//   enable      in   start / keep running timesteps
//   spike_in    in   level spike inputs, rising edge = spike
//   bus         master: upd_valid/upd_idx/upd_ready, leak_valid/leak_ready
//   tick        out  one-cycle pulse at timestep completion
//   step_count  out  completed timesteps (wraps)
//   drop_flags  out  sticky per-channel lost-spike flags
//   busy        out  scheduler not idle
// -----------------------------------------------------------------------------
module snn_spike_scheduler
    import snn_spike_scheduler_pkg::*;
#(
    parameter int N_IN            = 4,
    parameter int TIMESTEP_CYCLES = 16
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       enable,
    input  logic [N_IN-1:0]            spike_in,
    snn_spike_scheduler_if.master      bus,
    output logic                       tick,
    output logic [STEP_W-1:0]          step_count,
    output logic [N_IN-1:0]            drop_flags,
    output logic                       busy
);

    localparam int IDX_W = $clog2(N_IN);
    localparam int TMR_W = $clog2(TIMESTEP_CYCLES);
    localparam logic [TMR_W-1:0] TIMER_LOAD = TMR_W'(TIMESTEP_CYCLES - 1);
    localparam logic [N_IN-1:0]  ONE_HOT0   = {{(N_IN-1){1'b0}}, 1'b1};

    sched_state_t      state_r, state_s;
    logic [TMR_W-1:0]  timer_r, timer_s;
    logic [N_IN-1:0]   spike_q_r, spk_s;
    logic [N_IN-1:0]   pend_r, pend_s;
    logic [N_IN-1:0]   next_pend_r, next_pend_s;
    logic [N_IN-1:0]   drop_flags_r, drop_s;
    logic [N_IN-1:0]   hs_mask_s;
    logic [IDX_W-1:0]  rr_ptr_r, upd_idx_r, gnt_idx_s;
    logic              gnt_any_s, grant_s, hs_s, leak_hs_s;
    logic              upd_valid_r, leak_valid_r, tick_r, busy_r;
    logic [STEP_W-1:0] step_count_r;

    assign spk_s     = spike_in & ~spike_q_r;
    assign hs_s      = upd_valid_r & bus.upd_ready;
    assign leak_hs_s = leak_valid_r & bus.leak_ready;
    assign hs_mask_s = hs_s ? (ONE_HOT0 << upd_idx_r) : {N_IN{1'b0}};

    // A new grant is only launched once the previous request has retired,
    // which is what forces the idle cycle between back-to-back updates.
    assign grant_s = ((state_r == RUN) || (state_r == DRAIN)) && !upd_valid_r && gnt_any_s;

    snn_spike_scheduler_rr_arbiter #(
        .N  (N_IN),
        .IW (IDX_W)
    ) u_arb (
        .req     (pend_r),
        .ptr     (rr_ptr_r),
        .gnt_idx (gnt_idx_s),
        .gnt_any (gnt_any_s)
    );

    // Next-state and timestep timer.
    always_comb begin
        state_s = state_r;
        timer_s = timer_r;
        case (state_r)
            IDLE: begin
                if (enable) begin
                    state_s = RUN;
                    timer_s = TIMER_LOAD;
                end else begin
                    state_s = IDLE;
                end
            end
            RUN: begin
                if (timer_r == '0) begin
                    state_s = DRAIN;
                end else begin
                    timer_s = timer_r - TMR_W'(1);
                end
            end
            DRAIN: begin
                if ((pend_r == '0) && !upd_valid_r) begin
                    state_s = LEAK;
                end else begin
                    state_s = DRAIN;
                end
            end
            LEAK: begin
                if (leak_hs_s) begin
                    state_s = TICK;
                end else begin
                    state_s = LEAK;
                end
            end
            TICK: begin
                if (enable) begin
                    state_s = RUN;
                    timer_s = TIMER_LOAD;
                end else begin
                    state_s = IDLE;
                end
            end
            default: begin
                state_s = IDLE;
            end
        endcase
    end

    // Pending-spike bookkeeping. Once RUN is over, new spikes belong to the
    // following timestep and collect in next_pend instead of pend.
    always_comb begin
        pend_s      = pend_r & ~hs_mask_s;
        next_pend_s = next_pend_r;
        drop_s      = {N_IN{1'b0}};
        case (state_r)
            RUN: begin
                // A spike landing on the bit being retired this cycle simply re-arms it.
                drop_s = spk_s & pend_r & ~hs_mask_s;
                pend_s = pend_s | spk_s;
            end
            DRAIN, LEAK: begin
                drop_s      = spk_s & next_pend_r;
                next_pend_s = next_pend_r | spk_s;
            end
            TICK: begin
                pend_s      = next_pend_r;
                next_pend_s = spk_s;
            end
            default: begin
                pend_s = pend_s;
            end
        endcase
    end

    // State, timer and edge-detect history.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r   <= IDLE;
            timer_r   <= '0;
            spike_q_r <= '0;
        end else begin
            state_r   <= state_s;
            timer_r   <= timer_s;
            spike_q_r <= spike_in;
        end
    end

    // Pending sets and sticky drop flags.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pend_r       <= '0;
            next_pend_r  <= '0;
            drop_flags_r <= '0;
        end else begin
            pend_r       <= pend_s;
            next_pend_r  <= next_pend_s;
            drop_flags_r <= drop_flags_r | drop_s;
        end
    end

    // Update handshake register and round-robin pointer.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            upd_valid_r <= 1'b0;
            upd_idx_r   <= '0;
            rr_ptr_r    <= '0;
        end else if (hs_s) begin
            upd_valid_r <= 1'b0;
            rr_ptr_r    <= upd_idx_r;
        end else if (grant_s) begin
            upd_valid_r <= 1'b1;
            upd_idx_r   <= gnt_idx_s;
        end else begin
            upd_valid_r <= upd_valid_r;
        end
    end

    // Status outputs decoded from the next state so they align with it.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            leak_valid_r <= 1'b0;
            tick_r       <= 1'b0;
            busy_r       <= 1'b0;
            step_count_r <= '0;
        end else begin
            leak_valid_r <= (state_s == LEAK);
            tick_r       <= (state_s == TICK);
            busy_r       <= (state_s != IDLE);
            if (state_s == TICK) begin
                step_count_r <= step_count_r + STEP_W'(1);
            end else begin
                step_count_r <= step_count_r;
            end
        end
    end

    assign bus.upd_valid  = upd_valid_r;
    assign bus.upd_idx    = upd_idx_r;
    assign bus.leak_valid = leak_valid_r;
    assign tick           = tick_r;
    assign step_count     = step_count_r;
    assign drop_flags     = drop_flags_r;
    assign busy           = busy_r;

endmodule

// File: tb/tb_snn_spike_scheduler.sv
// -----------------------------------------------------------------------------
// tb_snn_spike_scheduler
// Scenario-driven bench for snn_spike_scheduler (N_IN=4, TIMESTEP_CYCLES=16).
// Expected update indices go into a queue as spikes are driven; the monitor
// pops and compares on every observed handshake.
// -----------------------------------------------------------------------------
module tb_snn_spike_scheduler;

    logic        clk = 1'b0;
    logic        rst;
    logic        enable;
    logic [3:0]  spike_in;
    logic        tick;
    logic [15:0] step_count;
    logic [3:0]  drop_flags;
    logic        busy;

    int checks = 0;
    int errors = 0;
    int hs_count = 0;
    int leak_count = 0;
    int cyc_cnt = 0;
    logic [1:0] exp_q[$];
    int hs_times[$];

    snn_spike_scheduler_if #(.IDX_W(2)) bus ();

    snn_spike_scheduler #(
        .N_IN            (4),
        .TIMESTEP_CYCLES (16)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .enable     (enable),
        .spike_in   (spike_in),
        .bus        (bus),
        .tick       (tick),
        .step_count (step_count),
        .drop_flags (drop_flags),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

    // Scoreboard monitor, sampled on the falling edge.
    always @(negedge clk) begin
        logic [1:0] exp_v;
        if (rst === 1'b1) begin
            if (bus.upd_valid === 1'b1 && bus.upd_ready === 1'b1) begin
                hs_count++;
                hs_times.push_back(cyc_cnt);
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL upd_unexpected got idx=%0d expected no update", bus.upd_idx);
                end else begin
                    exp_v = exp_q.pop_front();
                    if (bus.upd_idx !== exp_v) begin
                        errors++;
                        $display("FAIL upd_idx got %0d expected %0d", bus.upd_idx, exp_v);
                    end
                end
            end
            if (bus.leak_valid === 1'b1 && bus.leak_ready === 1'b1) leak_count++;
            checks++;
            if ((bus.upd_valid & bus.leak_valid) !== 1'b0) begin
                errors++;
                $display("FAIL valid_exclusive got upd_valid=%b leak_valid=%b expected not both 1",
                         bus.upd_valid, bus.leak_valid);
            end
        end
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wait_tick(input int max_cyc, output int waited, output bit seen);
        seen   = 1'b0;
        waited = 0;
        while (!seen && waited < max_cyc) begin
            step(1);
            waited++;
            if (tick === 1'b1) seen = 1'b1;
        end
    endtask

    task automatic do_reset();
        enable = 1'b0;
        rst    = 1'b0;
        step(2);
        rst    = 1'b1;
        step(1);
    endtask

    task automatic test_reset();
        rst = 1'b0;
        enable = 1'b0;
        spike_in = 4'h0;
        bus.upd_ready = 1'b0;
        bus.leak_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            spike_in = 4'($urandom_range(0, 15));
            step(1);
        end
        checks++;
        if ({bus.upd_valid, bus.upd_idx, bus.leak_valid, tick, step_count, drop_flags, busy} !== 26'd0) begin
            errors++;
            $display("FAIL reset_outputs got %b expected all 0",
                     {bus.upd_valid, bus.upd_idx, bus.leak_valid, tick, step_count, drop_flags, busy});
        end
        spike_in = 4'h0;
        rst = 1'b1;
        step(3);
        checks++;
        if (busy !== 1'b0 || bus.upd_valid !== 1'b0) begin
            errors++;
            $display("FAIL idle_after_reset got busy=%b upd_valid=%b expected 0 0", busy, bus.upd_valid);
        end
        // Spikes while idle are ignored.
        spike_in = 4'hF;
        step(3);
        checks++;
        if (busy !== 1'b0 || bus.upd_valid !== 1'b0) begin
            errors++;
            $display("FAIL idle_spikes got busy=%b upd_valid=%b expected 0 0", busy, bus.upd_valid);
        end
        spike_in = 4'h0;
        step(1);
    endtask

    task automatic test_single_spike();
        int waited;
        bit seen;
        int base_hs;
        int base_leak;
        base_hs = hs_count;
        base_leak = leak_count;
        bus.upd_ready = 1'b1;
        bus.leak_ready = 1'b1;
        enable = 1'b1;
        step(3);
        spike_in[2] = 1'b1;
        exp_q.push_back(2'd2);
        wait_tick(40, waited, seen);
        checks++;
        if (!seen) begin
            errors++;
            $display("FAIL single_tick got no tick expected tick within 40 cycles");
        end
        // 1 entry cycle + 16 RUN + 1 DRAIN + 1 LEAK.
        checks++;
        if (3 + waited != 19) begin
            errors++;
            $display("FAIL single_tick_time got %0d cycles expected 19", 3 + waited);
        end
        checks++;
        if (step_count !== 16'd1) begin
            errors++;
            $display("FAIL single_step_count got %0d expected 1", step_count);
        end
        checks++;
        if (hs_count - base_hs != 1 || leak_count - base_leak != 1) begin
            errors++;
            $display("FAIL single_counts got upd=%0d leak=%0d expected 1 1",
                     hs_count - base_hs, leak_count - base_leak);
        end
        enable = 1'b0;
        spike_in = 4'h0;
        step(2);
        checks++;
        if (busy !== 1'b0 || tick !== 1'b0) begin
            errors++;
            $display("FAIL single_idle got busy=%b tick=%b expected 0 0", busy, tick);
        end
    endtask

    task automatic test_round_robin();
        int n;
        int waited;
        bit seen;
        do_reset();
        bus.upd_ready = 1'b0;
        enable = 1'b1;
        step(2);
        spike_in = 4'hF;
        exp_q.push_back(2'd1);
        exp_q.push_back(2'd2);
        exp_q.push_back(2'd3);
        exp_q.push_back(2'd0);
        n = 0;
        while (bus.upd_valid !== 1'b1 && n < 10) begin
            step(1);
            n++;
        end
        checks++;
        if (bus.upd_valid !== 1'b1) begin
            errors++;
            $display("FAIL rr_first_valid got upd_valid=%b expected 1", bus.upd_valid);
        end
        for (int i = 0; i < 5; i++) begin
            step(1);
            checks++;
            if (bus.upd_valid !== 1'b1 || bus.upd_idx !== 2'd1) begin
                errors++;
                $display("FAIL rr_hold got valid=%b idx=%0d expected 1 1", bus.upd_valid, bus.upd_idx);
            end
        end
        hs_times.delete();
        bus.upd_ready = 1'b1;
        wait_tick(40, waited, seen);
        checks++;
        if (!seen || exp_q.size() != 0) begin
            errors++;
            $display("FAIL rr_done got tick=%b left=%0d expected 1 0", seen, exp_q.size());
        end
        checks++;
        if (hs_times.size() != 4) begin
            errors++;
            $display("FAIL rr_hs_count got %0d expected 4", hs_times.size());
        end else begin
            for (int i = 1; i < 4; i++) begin
                checks++;
                if (hs_times[i] - hs_times[i-1] != 2) begin
                    errors++;
                    $display("FAIL rr_spacing got %0d expected 2", hs_times[i] - hs_times[i-1]);
                end
            end
        end
        checks++;
        if (step_count !== 16'd1 || drop_flags !== 4'b0000) begin
            errors++;
            $display("FAIL rr_status got step=%0d drop=%b expected 1 0000", step_count, drop_flags);
        end
        enable = 1'b0;
        step(2);
        spike_in = 4'h0;
        step(1);
    endtask

    task automatic test_drop();
        int base_hs;
        int waited;
        bit seen;
        base_hs = hs_count;
        bus.upd_ready = 1'b0;
        enable = 1'b1;
        step(2);
        spike_in = 4'b0001;
        exp_q.push_back(2'd0);
        step(1);
        spike_in = 4'b0000;
        step(1);
        spike_in = 4'b0001;
        step(2);
        checks++;
        if (drop_flags !== 4'b0001) begin
            errors++;
            $display("FAIL drop_flag got %b expected 0001", drop_flags);
        end
        bus.upd_ready = 1'b1;
        wait_tick(40, waited, seen);
        checks++;
        if (!seen || hs_count - base_hs != 1) begin
            errors++;
            $display("FAIL drop_single_update got tick=%b updates=%0d expected 1 1", seen, hs_count - base_hs);
        end
        checks++;
        if (step_count !== 16'd2 || drop_flags !== 4'b0001) begin
            errors++;
            $display("FAIL drop_status got step=%0d drop=%b expected 2 0001", step_count, drop_flags);
        end
        enable = 1'b0;
        spike_in = 4'h0;
        step(2);
    endtask

    task automatic test_boundary();
        int base_hs;
        int waited;
        int n;
        bit seen;
        base_hs = hs_count;
        bus.upd_ready = 1'b0;
        enable = 1'b1;
        step(2);
        spike_in = 4'b0010;
        exp_q.push_back(2'd1);
        step(20);
        checks++;
        if (busy !== 1'b1 || bus.upd_valid !== 1'b1 || bus.upd_idx !== 2'd1 || tick !== 1'b0 || bus.leak_valid !== 1'b0) begin
            errors++;
            $display("FAIL drain_hold got busy=%b valid=%b idx=%0d tick=%b leak=%b expected 1 1 1 0 0",
                     busy, bus.upd_valid, bus.upd_idx, tick, bus.leak_valid);
        end
        spike_in = 4'b1010;
        exp_q.push_back(2'd3);
        step(1);
        bus.upd_ready = 1'b1;
        wait_tick(20, waited, seen);
        checks++;
        if (!seen || hs_count - base_hs != 1) begin
            errors++;
            $display("FAIL boundary_step got tick=%b updates=%0d expected 1 1", seen, hs_count - base_hs);
        end
        checks++;
        if (step_count !== 16'd3) begin
            errors++;
            $display("FAIL boundary_step_count got %0d expected 3", step_count);
        end
        n = 0;
        while (hs_count - base_hs < 2 && n < 10) begin
            step(1);
            n++;
        end
        checks++;
        if (hs_count - base_hs != 2 || exp_q.size() != 0) begin
            errors++;
            $display("FAIL boundary_next got updates=%0d left=%0d expected 2 0", hs_count - base_hs, exp_q.size());
        end
        checks++;
        if (drop_flags !== 4'b0001) begin
            errors++;
            $display("FAIL boundary_drop got %b expected 0001", drop_flags);
        end
    endtask

    task automatic test_stop_mid_run();
        int waited;
        bit seen;
        step(3);
        enable = 1'b0;
        spike_in = 4'h0;
        wait_tick(30, waited, seen);
        checks++;
        if (!seen || waited < 10) begin
            errors++;
            $display("FAIL stop_completes got tick=%b after %0d cycles expected 1 after >=10", seen, waited);
        end
        checks++;
        if (step_count !== 16'd4) begin
            errors++;
            $display("FAIL stop_step_count got %0d expected 4", step_count);
        end
        step(1);
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL stop_idle got busy=%b expected 0", busy);
        end
        step(3);
        checks++;
        if (busy !== 1'b0 || bus.upd_valid !== 1'b0 || tick !== 1'b0) begin
            errors++;
            $display("FAIL stop_hold got busy=%b valid=%b tick=%b expected 0 0 0", busy, bus.upd_valid, tick);
        end
    endtask

    task automatic test_reset_in_leak();
        int n;
        bus.leak_ready = 1'b0;
        bus.upd_ready = 1'b1;
        enable = 1'b1;
        n = 0;
        while (bus.leak_valid !== 1'b1 && n < 40) begin
            step(1);
            n++;
        end
        checks++;
        if (bus.leak_valid !== 1'b1 || step_count !== 16'd4) begin
            errors++;
            $display("FAIL leak_reached got leak=%b step=%0d expected 1 4", bus.leak_valid, step_count);
        end
        enable = 1'b0;
        rst = 1'b0;
        #1;
        checks++;
        if (bus.leak_valid !== 1'b0 || step_count !== 16'd0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_in_leak got leak=%b step=%0d busy=%b expected 0 0 0",
                     bus.leak_valid, step_count, busy);
        end
        step(1);
        rst = 1'b1;
        bus.leak_ready = 1'b1;
        step(2);
        checks++;
        if (busy !== 1'b0 || drop_flags !== 4'b0000) begin
            errors++;
            $display("FAIL post_reset got busy=%b drop=%b expected 0 0000", busy, drop_flags);
        end
    endtask

    initial begin
        rst = 1'b0;
        enable = 1'b0;
        spike_in = 4'h0;
        bus.upd_ready = 1'b0;
        bus.leak_ready = 1'b1;
        test_reset();
        test_single_spike();
        test_round_robin();
        test_drop();
        test_boundary();
        test_stop_mid_run();
        test_reset_in_leak();
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_empty got %0d outstanding expected 0", exp_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
